// File: rtl/pipe_ctrl_n_pkg.sv
// Shared constants and drain FSM encoding for the pipeline stall/flush controller.
package pipe_ctrl_n_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } drain_st_e;

  localparam int STAGE_IF = 0;
  localparam int STAGE_ID = 1;

  localparam logic [4:0] GPR_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_n_req_counter.sv
// Outstanding-request counter: bumps on accepted request, drops on response,
// and flags a response that arrives with nothing outstanding.
module req_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req,
  input  logic         addr_ok,
  input  logic         data_ok,
  output logic [W-1:0] cnt,
  output logic         req_ok,
  output logic         proto_err
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic         acc;
  logic [W-1:0] cnt_nxt;

  assign acc    = req && addr_ok;
  assign req_ok = (cnt != CNT_MAX);

  always_comb begin
    cnt_nxt = cnt;
    if (acc && !data_ok)
      cnt_nxt = cnt + 1'b1;
    else if (!acc && data_ok && cnt != '0)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (data_ok && cnt == '0)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// N-register hold/clear generator with ID RAW hazard detection, bus request
// tracking and a drain FSM that discards responses of cancelled fetches.
module pipe_ctrl_n
  import pipe_ctrl_n_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int OUTST_W    = 2,
  parameter int FWD_EN     = 1,
  parameter int EXC_STAGE  = 3,
  parameter int DMEM_STAGE = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    inst_req,
  input  logic                    inst_addr_ok,
  input  logic                    inst_data_ok,
  input  logic                    data_req,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  input  logic                    id_rs_ren,
  input  logic [4:0]              id_rs,
  input  logic                    id_rt_ren,
  input  logic [4:0]              id_rt,
  input  logic                    id_branch,
  input  logic [STAGES-3:0]       prod_wen,
  input  logic [5*(STAGES-2)-1:0] prod_wreg,
  input  logic [STAGES-3:0]       prod_late,
  input  logic [STAGES:0]         ext_busy,
  input  logic                    exc_oc,
  input  logic                    eret,
  output logic [STAGES-1:0]       hold,
  output logic [STAGES-1:0]       clr,
  output logic                    inst_req_ok,
  output logic                    data_req_ok,
  output logic                    inst_discard,
  output logic                    proto_err
);

  localparam int NPROD = STAGES - 2;

  logic [OUTST_W-1:0] inst_cnt, data_cnt, inst_left;
  logic               inst_perr, data_perr;
  logic               flush, id_haz, if_wait, dmem_wait;
  logic [NPROD-1:0]   match, stall_on;
  logic [STAGES:0]    busy;

  drain_st_e          state, state_nxt;
  logic [OUTST_W-1:0] cancel_cnt, cancel_nxt;

  req_counter #(.W(OUTST_W)) u_inst_cnt (
    .clk(clk), .resetn(resetn), .req(inst_req), .addr_ok(inst_addr_ok),
    .data_ok(inst_data_ok), .cnt(inst_cnt), .req_ok(inst_req_ok), .proto_err(inst_perr)
  );

  req_counter #(.W(OUTST_W)) u_data_cnt (
    .clk(clk), .resetn(resetn), .req(data_req), .addr_ok(data_addr_ok),
    .data_ok(data_data_ok), .cnt(data_cnt), .req_ok(data_req_ok), .proto_err(data_perr)
  );

  assign proto_err = inst_perr || data_perr;
  assign flush     = exc_oc || eret;

  // Producer p sits in stage p+2; p==0 (EX) can only forward at stage end.
  for (genvar p = 0; p < NPROD; p++) begin : g_prod
    logic [4:0] wreg;
    assign wreg     = prod_wreg[5*p +: 5];
    assign match[p] = prod_wen[p] && (wreg != GPR_ZERO) &&
                      ((id_rs_ren && wreg == id_rs) || (id_rt_ren && wreg == id_rt));
    if (FWD_EN != 0) begin : g_fwd
      assign stall_on[p] = match[p] && prod_late[p] && ((p == 0) || id_branch);
    end else begin : g_nofwd
      assign stall_on[p] = match[p];
    end
  end

  assign id_haz    = |stall_on;
  assign if_wait   = !(inst_data_ok && !inst_discard);
  assign dmem_wait = (data_req && !data_addr_ok) || (data_cnt != '0 && !data_data_ok);

  always_comb begin
    busy             = ext_busy;
    busy[STAGE_IF]   = busy[STAGE_IF] | if_wait;
    busy[STAGE_ID]   = busy[STAGE_ID] | id_haz;
    busy[DMEM_STAGE] = busy[DMEM_STAGE] | dmem_wait;
  end

  // A register holds while anything downstream is busy; the first register
  // behind a busy stage with free downstream loads a bubble. Flush wins.
  for (genvar k = 0; k < STAGES; k++) begin : g_reg
    localparam bit IN_FLUSH = (k <= EXC_STAGE);
    logic below;
    assign below  = |busy[STAGES:k+1];
    assign hold[k] = below && !(flush && IN_FLUSH);
    assign clr[k]  = flush ? IN_FLUSH : (busy[k] && !below);
  end

  // Fetches still outstanding after this cycle; these are the ones a flush cancels.
  always_comb begin
    inst_left = inst_cnt;
    if (inst_req && inst_addr_ok && !inst_data_ok)
      inst_left = inst_cnt + 1'b1;
    else if (!(inst_req && inst_addr_ok) && inst_data_ok && inst_cnt != '0)
      inst_left = inst_cnt - 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    cancel_nxt   = cancel_cnt;
    inst_discard = 1'b0;
    if (flush) begin
      cancel_nxt = inst_left;
      state_nxt  = (inst_left != '0) ? ST_DRAIN : ST_RUN;
    end else if (state == ST_DRAIN) begin
      inst_discard = inst_data_ok;
      if (inst_data_ok) begin
        cancel_nxt = cancel_cnt - 1'b1;
        if (cancel_cnt == OUTST_W'(1))
          state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RUN;
      cancel_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cancel_cnt <= cancel_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n: hazards, stalls, counters, flush drain, reset.
module tb_pipe_ctrl_n;

  logic       clk = 1'b0;
  logic       resetn;
  logic       inst_req, inst_addr_ok, inst_data_ok;
  logic       data_req, data_addr_ok, data_data_ok;
  logic       id_rs_ren, id_rt_ren, id_branch;
  logic [4:0] id_rs, id_rt;
  logic [1:0] prod_wen, prod_late;
  logic [9:0] prod_wreg;
  logic [4:0] ext_busy;
  logic       exc_oc, eret;

  logic [3:0] hold0, clr0, hold1, clr1;
  logic       iok0, dok0, disc0, perr0;
  logic       iok1, dok1, disc1, perr1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_n #(.STAGES(4), .OUTST_W(2), .FWD_EN(1), .EXC_STAGE(3), .DMEM_STAGE(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .id_rs_ren(id_rs_ren), .id_rs(id_rs), .id_rt_ren(id_rt_ren), .id_rt(id_rt),
    .id_branch(id_branch), .prod_wen(prod_wen), .prod_wreg(prod_wreg), .prod_late(prod_late),
    .ext_busy(ext_busy), .exc_oc(exc_oc), .eret(eret),
    .hold(hold0), .clr(clr0), .inst_req_ok(iok0), .data_req_ok(dok0),
    .inst_discard(disc0), .proto_err(perr0)
  );

  pipe_ctrl_n #(.STAGES(4), .OUTST_W(2), .FWD_EN(0), .EXC_STAGE(3), .DMEM_STAGE(3)) dut_nofwd (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .id_rs_ren(id_rs_ren), .id_rs(id_rs), .id_rt_ren(id_rt_ren), .id_rt(id_rt),
    .id_branch(id_branch), .prod_wen(prod_wen), .prod_wreg(prod_wreg), .prod_late(prod_late),
    .ext_busy(ext_busy), .exc_oc(exc_oc), .eret(eret),
    .hold(hold1), .clr(clr1), .inst_req_ok(iok1), .data_req_ok(dok1),
    .inst_discard(disc1), .proto_err(perr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    {inst_req, inst_addr_ok, inst_data_ok} = '0;
    {data_req, data_addr_ok, data_data_ok} = '0;
    {id_rs_ren, id_rt_ren, id_branch} = '0;
    id_rs = '0; id_rt = '0;
    prod_wen = '0; prod_late = '0; prod_wreg = '0;
    ext_busy = '0; exc_oc = 1'b0; eret = 1'b0;

    #3;
    chk("reset_inst_ok", iok0, 1);
    chk("reset_data_ok", dok0, 1);
    chk("reset_proto", perr0, 0);
    chk("reset_discard", disc0, 0);
    chk("reset_hold", hold0, 4'b0000);
    chk("reset_clr", clr0, 4'b0001);
    #10 resetn = 1'b1;
    step();

    // Load in EX feeding ID
    prod_wen = 2'b01; prod_late = 2'b01; prod_wreg = 10'd8; id_rs_ren = 1'b1; id_rs = 5'd8;
    #2;
    chk("lu_hold", hold0, 4'b0001);
    chk("lu_clr", clr0, 4'b0010);
    chk("lu_hold_nofwd", hold1, 4'b0001);
    prod_late = 2'b00;
    #2;
    chk("fwd_hold", hold0, 4'b0000);
    chk("fwd_clr", clr0, 4'b0001);
    chk("fwd_hold_nofwd", hold1, 4'b0001);
    prod_late = 2'b01; id_rs_ren = 1'b0; id_rt_ren = 1'b1; id_rt = 5'd8;
    #2;
    chk("rt_hold", hold0, 4'b0001);
    prod_wreg = 10'd0; id_rt = 5'd0;
    #2;
    chk("r0_hold", hold0, 4'b0000);
    chk("r0_hold_nofwd", hold1, 4'b0000);

    // Branch in ID vs late producer in MEM
    prod_wen = 2'b10; prod_wreg = {5'd9, 5'd0}; prod_late = 2'b10;
    id_rt_ren = 1'b0; id_rs_ren = 1'b1; id_rs = 5'd9; id_branch = 1'b1;
    #2;
    chk("br_hold", hold0, 4'b0001);
    chk("br_clr", clr0, 4'b0010);
    id_branch = 1'b0;
    #2;
    chk("nobr_hold", hold0, 4'b0000);
    prod_late = 2'b00; id_branch = 1'b1;
    #2;
    chk("br_nolate_hold", hold0, 4'b0000);
    chk("br_nolate_nofwd", hold1, 4'b0001);
    prod_wen = '0; prod_late = '0; prod_wreg = '0;
    id_rs_ren = 1'b0; id_rs = '0; id_branch = 1'b0;

    // Divider busy in EX
    ext_busy = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div_hold", hold0, 4'b0011);
      chk("div_clr", clr0, 4'b0100);
    end
    ext_busy = '0;
    #2;
    chk("div_rel_hold", hold0, 4'b0000);
    chk("div_rel_clr", clr0, 4'b0001);

    // Data request not accepted
    data_req = 1'b1; data_addr_ok = 1'b0;
    #2;
    chk("dreq_hold", hold0, 4'b0111);
    chk("dreq_clr", clr0, 4'b1000);
    step();

    // Fill the data counter
    data_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("fill_ok", dok0, 1);
      step();
    end
    chk("full_ok", dok0, 0);
    chk("full_hold", hold0, 4'b0111);
    data_data_ok = 1'b1;
    step();
    chk("full_same", dok0, 0);
    data_req = 1'b0; data_addr_ok = 1'b0;
    step();
    chk("one_free", dok0, 1);
    step();
    step();
    data_data_ok = 1'b0;
    #2;
    chk("drained_hold", hold0, 4'b0000);
    chk("drained_proto", perr0, 0);

    // Three fetches outstanding, exception cancels them
    inst_req = 1'b1; inst_addr_ok = 1'b1;
    step(); step(); step();
    inst_req = 1'b0; inst_addr_ok = 1'b0;
    chk("inst_full", iok0, 0);
    exc_oc = 1'b1; ext_busy = 5'b00100;
    #2;
    chk("flush_clr", clr0, 4'b1111);
    chk("flush_hold", hold0, 4'b0000);
    chk("flush_discard", disc0, 0);
    step();
    exc_oc = 1'b0; ext_busy = '0; inst_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("drain_discard", disc0, 1);
      chk("drain_clr", clr0, 4'b0001);
      step();
    end
    inst_data_ok = 1'b0;
    chk("drained_inst_ok", iok0, 1);
    inst_req = 1'b1; inst_addr_ok = 1'b1;
    step();
    inst_req = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
    #2;
    chk("run_discard", disc0, 0);
    chk("run_clr", clr0, 4'b0000);
    step();
    inst_data_ok = 1'b0;

    // Fetch in the eret cycle is cancelled, fetch right after it is kept
    inst_req = 1'b1; inst_addr_ok = 1'b1; eret = 1'b1;
    #2;
    chk("eret_clr", clr0, 4'b1111);
    step();
    eret = 1'b0;
    step();
    inst_req = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
    #2;
    chk("old_discard", disc0, 1);
    step();
    #2;
    chk("new_keep", disc0, 0);
    step();
    inst_data_ok = 1'b0;
    chk("no_proto", perr0, 0);

    // Response with nothing outstanding
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    #2;
    chk("proto_set", perr0, 1);
    step(); step();
    chk("proto_sticky", perr0, 1);

    // Asynchronous reset while draining
    inst_req = 1'b1; inst_addr_ok = 1'b1;
    step(); step(); step();
    inst_req = 1'b0; inst_addr_ok = 1'b0; exc_oc = 1'b1;
    step();
    exc_oc = 1'b0; inst_data_ok = 1'b1;
    #1;
    chk("pre_rst_discard", disc0, 1);
    chk("pre_rst_inst_ok", iok0, 0);
    resetn = 1'b0;
    #1;
    chk("rst_discard", disc0, 0);
    chk("rst_inst_ok", iok0, 1);
    chk("rst_proto", perr0, 0);
    inst_data_ok = 1'b0;
    #5 resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
